// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the DataRAM arbiter between the core load/store
// path and the external host preload/dump port.
package dmem_arb_pkg;

  localparam int unsigned ARB_AW         = 8;
  localparam int unsigned ARB_DW         = 8;
  localparam int unsigned ARB_STARVE_MAX = 4;
  localparam int unsigned ARB_CNT_W      = 4;
  localparam int unsigned STALL_CNT_W    = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_HOST = 2'd2
  } arb_state_t;

  function automatic logic core_req_f(input logic run, input logic rd, input logic wr);
    return run & (rd | wr);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, host and DataRAM signals around the arbiter; the slave
// modport is the arbiter's view, the master modport the surrounding system's.
interface dmem_arbiter_if #(
  parameter int unsigned AW = dmem_arb_pkg::ARB_AW,
  parameter int unsigned DW = dmem_arb_pkg::ARB_DW
) ();

  logic                                  core_run;
  logic                                  core_rd;
  logic                                  core_wr;
  logic [AW-1:0]                         core_addr;
  logic [DW-1:0]                         core_wdata;
  logic [DW-1:0]                         core_rdata;
  logic                                  core_stall;
  logic                                  host_req;
  logic                                  host_we;
  logic [AW-1:0]                         host_addr;
  logic [DW-1:0]                         host_wdata;
  logic                                  host_gnt;
  logic [DW-1:0]                         host_rdata;
  logic                                  host_rvalid;
  logic [AW-1:0]                         mem_addr;
  logic [DW-1:0]                         mem_wdata;
  logic                                  mem_rd;
  logic                                  mem_wr;
  logic [DW-1:0]                         mem_rdata;
  logic [dmem_arb_pkg::STALL_CNT_W-1:0]  stall_cycles;

  modport slave (
    input  core_run, core_rd, core_wr, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output core_rdata, core_stall, host_gnt, host_rdata, host_rvalid,
    output mem_addr, mem_wdata, mem_rd, mem_wr, stall_cycles
  );

  modport master (
    output core_run, core_rd, core_wr, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  core_rdata, core_stall, host_gnt, host_rdata, host_rvalid,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, stall_cycles
  );

endinterface

// File: rtl/dmem_arbiter_chk.sv
// Protocol checks on the arbiter boundary: the host must hold its request while
// waiting, and the core never issues a load and a store together.
module dmem_arbiter_chk (
  input logic CLK,
  input logic RESET_N,
  input logic in_wait_i,
  input logic host_req_i,
  input logic core_rd_i,
  input logic core_wr_i
);

  a_host_req_held: assert property (@(posedge CLK) disable iff (!RESET_N)
    in_wait_i |-> host_req_i)
    else $error("host_req dropped while waiting for grant");

  a_core_rd_wr_excl: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(core_rd_i && core_wr_i))
    else $error("core_rd and core_wr high together");

endmodule

// File: rtl/dmem_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones; used to count core stall cycles.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign count_d = (en_i && (count_q != {WIDTH{1'b1}}))
                 ? count_q + {{(WIDTH-1){1'b0}}, 1'b1}
                 : count_q;

  // count register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// DataRAM arbiter: core has zero-latency priority, host is granted through a
// registered handshake with a bounded wait of STARVE_MAX core-served cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = ARB_AW,
  parameter int unsigned DW         = ARB_DW,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
  input logic            CLK,
  input logic            RESET_N,
  dmem_arbiter_if.slave  bus
);

  localparam logic [ARB_CNT_W-1:0] STARVE_LIM = ARB_CNT_W'(STARVE_MAX);

  arb_state_t           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 core_req_s;
  logic                 host_sel_s;
  logic                 core_stall_s;
  logic [AW-1:0]        mem_addr_s;
  logic [DW-1:0]        mem_wdata_s;
  logic                 mem_rd_s;
  logic                 mem_wr_s;
  logic [DW-1:0]        host_rdata_q, host_rdata_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [STALL_CNT_W-1:0] stall_cycles_s;

  assign core_req_s   = core_req_f(bus.core_run, bus.core_rd, bus.core_wr);
  assign host_sel_s   = (state_q == ARB_HOST);
  assign core_stall_s = host_sel_s & core_req_s;

  // arbiter state and starvation counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ARB_IDLE;
      cnt_q   <= {ARB_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: HOST always lasts exactly one cycle so the core gets the next one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.host_req && !core_req_s) begin
          state_d = ARB_HOST;
        end else if (bus.host_req) begin
          state_d = ARB_WAIT;
          cnt_d   = ARB_CNT_W'(1);
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (!core_req_s || (cnt_q == STARVE_LIM)) begin
          state_d = ARB_HOST;
        end else begin
          cnt_d = cnt_q + ARB_CNT_W'(1);
        end
      end
      ARB_HOST: begin
        state_d = ARB_IDLE;
        cnt_d   = {ARB_CNT_W{1'b0}};
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = {ARB_CNT_W{1'b0}};
      end
    endcase
  end

  // DataRAM port mux
  always_comb begin
    mem_addr_s  = bus.core_addr;
    mem_wdata_s = bus.core_wdata;
    mem_rd_s    = bus.core_rd & bus.core_run;
    mem_wr_s    = bus.core_wr & bus.core_run;
    if (host_sel_s) begin
      mem_addr_s  = bus.host_addr;
      mem_wdata_s = bus.host_wdata;
      mem_rd_s    = ~bus.host_we;
      mem_wr_s    = bus.host_we;
    end else begin
      mem_rd_s    = bus.core_rd & bus.core_run;
    end
  end

  // host read data is captured at the edge that ends the HOST cycle
  always_comb begin
    host_rvalid_d = host_sel_s & ~bus.host_we;
    host_rdata_d  = host_rdata_q;
    if (host_rvalid_d) begin
      host_rdata_d = bus.mem_rdata;
    end else begin
      host_rdata_d = host_rdata_q;
    end
  end

  // host read return registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      host_rdata_q  <= {DW{1'b0}};
      host_rvalid_q <= 1'b0;
    end else begin
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .clk     (CLK),
    .clr_n   (RESET_N),
    .en_i    (core_stall_s),
    .count_o (stall_cycles_s)
  );

  dmem_arbiter_chk u_chk (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .in_wait_i  (state_q == ARB_WAIT),
    .host_req_i (bus.host_req),
    .core_rd_i  (bus.core_rd),
    .core_wr_i  (bus.core_wr)
  );

  assign bus.core_rdata   = bus.mem_rdata;
  assign bus.core_stall   = core_stall_s;
  assign bus.host_gnt     = host_sel_s;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.mem_addr     = mem_addr_s;
  assign bus.mem_wdata    = mem_wdata_s;
  assign bus.mem_rd       = mem_rd_s;
  assign bus.mem_wr       = mem_wr_s;
  assign bus.stall_cycles = stall_cycles_s;

endmodule
